// File: rtl/memctrl_host_pkg.sv
// Shared types and constants for the MEMCTRL host-side sequencer.
package memctrl_host_pkg;

  // Transaction phases, in the order a transaction walks through them
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    HOLD1 = 3'd2,
    GAP1  = 3'd3,
    DATA  = 3'd4,
    GAP2  = 3'd5
  } state_e;

  // Default CE pulse timing, in clocks
  localparam int unsigned CE_HI_DEF = 3;
  localparam int unsigned CE_LO_DEF = 3;

  // Operation encoding carried in the op register
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/memctrl_host_seq.sv
// Host-side initiator for the MEMCTRL external bus: turns a valid/ready
// request stream into two-pulse CE transactions and captures read data.
// Optional expected-data checking is built when MEMCTRL_HOST_CHECK_EN is defined.
module memctrl_host_seq
  import memctrl_host_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CE_HI  = CE_HI_DEF,
  parameter int unsigned CE_LO  = CE_LO_DEF,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MEMCTRL_HOST_CHECK_EN
  input  logic [DATA_W-1:0] req_exp,
  output logic              rsp_mismatch,
  output logic [15:0]       err_cnt,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              CE,
  output logic              CSB,
  output logic              WEB,
  output logic              OEB,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] IDATA,
  input  logic [DATA_W-1:0] ODATA,
  output logic              BIST_EN,
  output logic              BISR_EN,
  output logic [2:0]        BIST_MODE
);

  localparam logic [2:0] S_IDLE  = 3'(IDLE);
  localparam logic [2:0] S_CMD   = 3'(CMD);
  localparam logic [2:0] S_HOLD1 = 3'(HOLD1);
  localparam logic [2:0] S_GAP1  = 3'(GAP1);
  localparam logic [2:0] S_DATA  = 3'(DATA);
  localparam logic [2:0] S_GAP2  = 3'(GAP2);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_HOLD1  = CNT_W'(CE_HI - 1);
  localparam logic [CNT_W-1:0] LD_GAP1   = CNT_W'(CE_LO);
  localparam logic [CNT_W-1:0] LD_DATA   = CNT_W'(CE_HI);
  localparam logic [CNT_W-1:0] LD_GAP2   = CNT_W'(CE_LO - 1);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             op_q;

  logic             last_c;
  logic             accept_c;
  logic             capture_c;
  logic             rsp_valid_d;
  logic             req_ready_d;
  logic             ce_d;
  logic             csb_d;
  logic             web_d;
  logic             oeb_d;

  // MEMCTRL stays in normal mode
  assign BIST_EN   = 1'b0;
  assign BISR_EN   = 1'b0;
  assign BIST_MODE = 3'b000;

  // Next-state, phase counter and next bus-pin values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_c      = (cnt_q == CNT_ONE);
    accept_c    = 1'b0;
    capture_c   = 1'b0;
    rsp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          state_d  = S_CMD;
          cnt_d    = CNT_ONE;
        end
      end
      S_CMD: begin
        if (CE_HI > 1) begin
          state_d = S_HOLD1;
          cnt_d   = LD_HOLD1;
        end else begin
          state_d = S_GAP1;
          cnt_d   = LD_GAP1;
        end
      end
      S_HOLD1: begin
        if (last_c) begin
          state_d = S_GAP1;
          cnt_d   = LD_GAP1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP1: begin
        if (last_c) begin
          state_d   = S_DATA;
          cnt_d     = LD_DATA;
          capture_c = (op_q == OP_RD);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (last_c) begin
          state_d = S_GAP2;
          cnt_d   = LD_GAP2;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP2: begin
        if (last_c) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pin values belong to the state being entered, so they can be registered
    ce_d        = 1'b0;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    oeb_d       = OEB;
    req_ready_d = (state_d == S_IDLE);

    case (state_d)
      S_IDLE: begin
        oeb_d = 1'b1;
      end
      S_CMD: begin
        // CMD is only entered on accept, so the op comes straight from the request
        ce_d  = 1'b1;
        csb_d = 1'b0;
        web_d = (req_wr == OP_RD);
        oeb_d = (req_wr == OP_WR);
      end
      S_HOLD1: begin
        ce_d = 1'b1;
      end
      S_GAP1: begin
        ce_d = 1'b0;
      end
      S_DATA: begin
        ce_d  = 1'b1;
        oeb_d = 1'b1;
      end
      S_GAP2: begin
        oeb_d = 1'b1;
      end
      default: begin
        oeb_d = 1'b1;
      end
    endcase
  end

  // State, counter, request latch and bus-pin registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_RD;
      CE        <= 1'b0;
      CSB       <= 1'b1;
      WEB       <= 1'b1;
      OEB       <= 1'b1;
      ADDR      <= '0;
      IDATA     <= '0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      CE        <= ce_d;
      CSB       <= csb_d;
      WEB       <= web_d;
      OEB       <= oeb_d;
      req_ready <= req_ready_d;
      if (accept_c) begin
        op_q  <= req_wr;
        ADDR  <= req_addr;
        IDATA <= req_wdata;
      end
    end
  end

  // Completion pulse and read-data capture at the end of the first CE gap
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rsp_valid_d;
      if (capture_c) begin
        rsp_rdata <= ODATA;
      end
    end
  end

`ifdef MEMCTRL_HOST_CHECK_EN
  logic [DATA_W-1:0] exp_q;
  logic              mism_c;

  // A read mismatches when the captured byte differs (X/Z included)
  always_comb begin
    mism_c = 1'b0;
    if (rsp_valid_d && (op_q == OP_RD)) begin
      mism_c = (rsp_rdata !== exp_q);
    end
  end

  // Expected-data latch, mismatch flag and saturating error counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_q        <= '0;
      rsp_mismatch <= 1'b0;
      err_cnt      <= '0;
    end else begin
      if (accept_c) begin
        exp_q <= req_exp;
      end
      rsp_mismatch <= mism_c;
      if (mism_c && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_memctrl_host_seq.sv
// Self-checking bench for memctrl_host_seq: waveform traces, a table of
// back-to-back requests with a response scoreboard, reset abort, and a
// short-timing instance (CE_HI=1, CE_LO=2).
module tb_memctrl_host_seq;

  typedef struct {
    logic [7:0] rdata;
    logic [7:0] expb;
    logic       mism;
  } sb_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
  } vec_t;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        CE, CSB, WEB, OEB;
  logic [15:0] ADDR;
  logic [7:0]  IDATA;
  logic [7:0]  ODATA;
  logic        BIST_EN, BISR_EN;
  logic [2:0]  BIST_MODE;

  logic        r2_valid, r2_ready, r2_wr;
  logic [15:0] r2_addr;
  logic [7:0]  r2_wdata;
  logic        r2_rsp_valid;
  logic [7:0]  r2_rdata;
  logic        CE2, CSB2, WEB2, OEB2;
  logic [15:0] ADDR2;
  logic [7:0]  IDATA2, ODATA2;
  logic        BIST_EN2, BISR_EN2;
  logic [2:0]  BIST_MODE2;

`ifdef MEMCTRL_HOST_CHECK_EN
  logic [7:0]  req_exp;
  logic        rsp_mismatch;
  logic [15:0] err_cnt;
  logic        rsp_mismatch2;
  logic [15:0] err_cnt2;
`endif

  logic [7:0]  mem [0:65535];
  sb_t         sb[$];
  sb_t         mon_e;
  vec_t        tbl[4];
  int          total;
  int          bad;
  int          cyc;
  int          acc_cyc;
  int          hold_bad;
  logic [15:0] cur_addr;
  logic [7:0]  cur_data;

  memctrl_host_seq dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEMCTRL_HOST_CHECK_EN
    .req_exp(req_exp), .rsp_mismatch(rsp_mismatch), .err_cnt(err_cnt),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB), .ADDR(ADDR), .IDATA(IDATA),
    .ODATA(ODATA), .BIST_EN(BIST_EN), .BISR_EN(BISR_EN), .BIST_MODE(BIST_MODE)
  );

  memctrl_host_seq #(.CE_HI(1), .CE_LO(2)) dut2 (
    .CLK(CLK), .RST(RST),
    .req_valid(r2_valid), .req_ready(r2_ready), .req_wr(r2_wr),
    .req_addr(r2_addr), .req_wdata(r2_wdata),
`ifdef MEMCTRL_HOST_CHECK_EN
    .req_exp(8'h3C), .rsp_mismatch(rsp_mismatch2), .err_cnt(err_cnt2),
`endif
    .rsp_valid(r2_rsp_valid), .rsp_rdata(r2_rdata),
    .CE(CE2), .CSB(CSB2), .WEB(WEB2), .OEB(OEB2), .ADDR(ADDR2), .IDATA(IDATA2),
    .ODATA(ODATA2), .BIST_EN(BIST_EN2), .BISR_EN(BISR_EN2), .BIST_MODE(BIST_MODE2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Bus model: write on the CMD pulse, drive stored byte while OEB is low
  always @(posedge CLK) begin
    if (CE && !CSB && !WEB) mem[ADDR] <= IDATA;
  end
  assign ODATA  = OEB  ? 8'h00 : mem[ADDR];
  assign ODATA2 = OEB2 ? 8'h00 : 8'h3C;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Address/data must not move while a transaction is in flight
  always @(negedge CLK) begin
    if (!RST && !req_ready && ((ADDR !== cur_addr) || (IDATA !== cur_data)))
      hold_bad <= hold_bad + 1;
  end

  // Response scoreboard
  always @(negedge CLK) begin
    if (!RST && rsp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 want no response");
      end else begin
        mon_e = sb.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
`ifdef MEMCTRL_HOST_CHECK_EN
        check("rsp_mismatch", 32'(rsp_mismatch), 32'(mon_e.mism));
`endif
      end
    end
  end

  // Present a request at a negedge, wait for acceptance, return one cycle later
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp_rd, input logic [7:0] exp_b, input logic mism);
    int n;
    sb_t e;
    n = 0;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
`ifdef MEMCTRL_HOST_CHECK_EN
    req_exp   = exp_b;
`endif
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready=0 want 1");
    end else begin
      e.rdata = exp_rd;
      e.expb  = exp_b;
      e.mism  = mism;
      sb.push_back(e);
      acc_cyc  = cyc;
      cur_addr = addr;
      cur_data = wdata;
    end
    @(negedge CLK);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0 || !req_ready) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got pending=%0d want 0", sb.size());
    end
  endtask

  // Single transaction with a 12-cycle pin trace starting at CMD
  task automatic trace_txn(input string tag, input logic wr, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rd,
                           input logic [11:0] exp_oeb, input logic [11:0] exp_web);
    logic [11:0] t_ce, t_csb, t_web, t_oeb, t_rdy, t_rv;
    issue(wr, addr, wdata, exp_rd, exp_rd, 1'b0);
    req_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      t_ce[12-i]  = CE;
      t_csb[12-i] = CSB;
      t_web[12-i] = WEB;
      t_oeb[12-i] = OEB;
      t_rdy[12-i] = req_ready;
      t_rv[12-i]  = rsp_valid;
      if (i < 12) @(negedge CLK);
    end
    check({tag, "_ce"},   32'(t_ce),  32'(12'b111000111000));
    check({tag, "_csb"},  32'(t_csb), 32'(12'b011111111111));
    check({tag, "_web"},  32'(t_web), 32'(exp_web));
    check({tag, "_oeb"},  32'(t_oeb), 32'(exp_oeb));
    check({tag, "_rdy"},  32'(t_rdy), 32'(12'b000000000001));
    check({tag, "_rv"},   32'(t_rv),  32'(12'b000000000001));
    check({tag, "_addr_idle"}, 32'(ADDR), 32'(addr));
  endtask

  initial begin
    int acc[4];
    int rv_cnt;
    logic [5:0] s_ce, s_oeb, s_rv, s_rdy;
    total = 0; bad = 0; cyc = 0; hold_bad = 0; acc_cyc = 0;
    cur_addr = '0; cur_data = '0;
    RST = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
`ifdef MEMCTRL_HOST_CHECK_EN
    req_exp = '0;
`endif
    r2_valid = 1'b0; r2_wr = 1'b0; r2_addr = '0; r2_wdata = '0;

    tbl[0] = '{1'b1, 16'h0001, 8'h11, 8'hA5};
    tbl[1] = '{1'b0, 16'h0001, 8'h00, 8'h11};
    tbl[2] = '{1'b1, 16'hFFFF, 8'hFF, 8'h11};
    tbl[3] = '{1'b0, 16'hFFFF, 8'h00, 8'hFF};

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_ctl", 32'({CE, CSB, WEB, OEB, req_ready, rsp_valid}), 32'(6'b011110));
    check("rst_data", 32'({ADDR, IDATA, rsp_rdata}), 32'h0);
    check("rst_bist", 32'({BIST_EN, BISR_EN, BIST_MODE}), 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    // Write, then read back the same location
    trace_txn("wr", 1'b1, 16'h1234, 8'hA5, 8'h00, 12'b111111111111, 12'b011111111111);
    check("wr_hold", 32'(hold_bad), 32'h0);
    trace_txn("rd", 1'b0, 16'h1234, 8'h00, 8'hA5, 12'b000000111111, 12'b111111111111);

    // Back-to-back table with req_valid held high
    for (int i = 0; i < 4; i++) begin
      issue(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_rd, 1'b0);
      acc[i] = acc_cyc;
    end
    req_valid = 1'b0;
    wait_idle();
    for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd12);
    check("b2b_hold", 32'(hold_bad), 32'h0);

    // Reset in the middle of GAP1 aborts the read with no response
    issue(1'b0, 16'h1234, 8'h00, 8'hA5, 8'hA5, 1'b0);
    req_valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("abort_in_gap1", 32'({CE, OEB}), 32'(2'b00));
    RST = 1'b1;
    #1;
    check("abort_ctl", 32'({CE, CSB, WEB, OEB, req_ready, rsp_valid}), 32'(6'b011110));
    check("abort_data", 32'({ADDR, IDATA, rsp_rdata}), 32'h0);
    sb.delete();
    rv_cnt = 0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    cur_addr = '0;
    cur_data = '0;
    repeat (15) begin
      @(negedge CLK);
      if (rsp_valid) rv_cnt++;
    end
    check("abort_no_rsp", 32'(rv_cnt), 32'h0);

    // Expected-data reads: first mismatches, second matches
    issue(1'b0, 16'h1234, 8'h00, 8'hA5, 8'h5A, 1'b1);
    req_valid = 1'b0;
    wait_idle();
`ifdef MEMCTRL_HOST_CHECK_EN
    check("err_cnt_1", 32'(err_cnt), 32'd1);
`endif
    issue(1'b0, 16'h1234, 8'h00, 8'hA5, 8'hA5, 1'b0);
    req_valid = 1'b0;
    wait_idle();
`ifdef MEMCTRL_HOST_CHECK_EN
    check("err_cnt_2", 32'(err_cnt), 32'd1);
`endif

    // Short timing instance: HOLD1 skipped, 5-cycle transaction
    r2_wr = 1'b0; r2_addr = 16'h0042; r2_valid = 1'b1;
    check("t2_ready", 32'(r2_ready), 32'h1);
    @(negedge CLK);
    r2_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      s_ce[6-i]  = CE2;
      s_oeb[6-i] = OEB2;
      s_rv[6-i]  = r2_rsp_valid;
      s_rdy[6-i] = r2_ready;
      if (i < 6) @(negedge CLK);
    end
    check("t2_ce",  32'(s_ce),  32'(6'b100100));
    check("t2_oeb", 32'(s_oeb), 32'(6'b000111));
    check("t2_rv",  32'(s_rv),  32'(6'b000001));
    check("t2_rdy", 32'(s_rdy), 32'(6'b000001));
    check("t2_rdata", 32'(r2_rdata), 32'h3C);

    repeat (2) @(negedge CLK);
    check("sb_empty", 32'(sb.size()), 32'h0);
    check("final_hold", 32'(hold_bad), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
